// File: rtl/mpu_matrix_loader_if.sv
// Stream-in / operand-out bundle for the MPU matrix loader.
// master = upstream feeder and multiplier side, slave = the loader itself.
interface mpu_matrix_loader_if #(
  parameter int DIM   = 5,
  parameter int WIDTH = 8
);
  logic                       flush;
  logic [WIDTH-1:0]           in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_last;
  logic [DIM*DIM*WIDTH-1:0]   matrix;
  logic [WIDTH-1:0]           factor;
  logic                       out_valid;
  logic                       out_ready;
  logic [4:0]                 fill_count;
  logic                       frame_err;

  modport master (
    output flush, in_data, in_valid, in_last, out_ready,
    input  in_ready, matrix, factor, out_valid, fill_count, frame_err
  );

  modport slave (
    input  flush, in_data, in_valid, in_last, out_ready,
    output in_ready, matrix, factor, out_valid, fill_count, frame_err
  );
endinterface

// File: rtl/mpu_matrix_loader.sv
// Assembles a DIMxDIM byte matrix plus one factor from a byte stream and holds it for the multiplier.
// Optional framing check on in_last: define MPU_LOADER_FRAME_CHECK_EN.
module mpu_matrix_loader #(
  parameter int DIM   = 5,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mpu_matrix_loader_if.slave   bus
);
  localparam int         NELEM      = DIM * DIM;
  localparam logic [4:0] FACTOR_IDX = 5'(NELEM);
  localparam logic [4:0] FULL_COUNT = 5'(NELEM + 1);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       fill_q, fill_d;
  logic [WIDTH-1:0] elem_q [NELEM];
  logic [WIDTH-1:0] elem_d [NELEM];
  logic [WIDTH-1:0] factor_q, factor_d;
  logic             frame_err_q, frame_err_d;
  logic             byte_ok;

`ifdef MPU_LOADER_FRAME_CHECK_EN
  // in_last must be set on the factor byte and only there
  assign byte_ok = (bus.in_last == (fill_q == FACTOR_IDX));
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign byte_ok        = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    elem_d      = elem_q;
    factor_d    = factor_q;
    frame_err_d = 1'b0;

    if (bus.flush) begin
      state_d = LOAD;
      fill_d  = '0;
    end else if (state_q == LOAD && bus.in_valid) begin
      if (!byte_ok) begin
        frame_err_d = 1'b1;
        fill_d      = '0;
      end else if (fill_q == FACTOR_IDX) begin
        factor_d = bus.in_data;
        fill_d   = FULL_COUNT;
        state_d  = FULL;
      end else begin
        elem_d[fill_q] = bus.in_data;
        fill_d         = fill_q + 5'd1;
      end
    end else if (state_q == FULL && bus.out_ready) begin
      // handoff leaves a one-cycle bubble before the next frame is accepted
      state_d = LOAD;
      fill_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      fill_q      <= '0;
      factor_q    <= '0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NELEM; i++) begin
        elem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      factor_q    <= factor_d;
      frame_err_q <= frame_err_d;
      elem_q      <= elem_d;
    end
  end

  for (genvar gi = 0; gi < NELEM; gi++) begin : g_matrix
    assign bus.matrix[gi*WIDTH +: WIDTH] = elem_q[gi];
  end

  assign bus.factor     = factor_q;
  assign bus.fill_count = fill_q;
  assign bus.in_ready   = (state_q == LOAD);
  assign bus.out_valid  = (state_q == FULL);
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Randomised bench for mpu_matrix_loader against a frame-level reference model.
// Framing-error scenarios run only when MPU_LOADER_FRAME_CHECK_EN is defined.
module tb_mpu_matrix_loader;
  localparam int DIM   = 5;
  localparam int WIDTH = 8;
  localparam int NELEM = DIM * DIM;
  localparam int MW    = NELEM * WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mpu_matrix_loader_if #(.DIM(DIM), .WIDTH(WIDTH)) bus ();

  mpu_matrix_loader #(.DIM(DIM), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: bytes of the frame collected so far (index NELEM is the factor)
  logic [7:0] mdl_buf [NELEM+1];
  int         mdl_fill;
  bit         mdl_full;
  bit         mdl_err;

  task automatic check_val(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mdl_fill = 0;
    mdl_full = 1'b0;
    mdl_err  = 1'b0;
    for (int i = 0; i <= NELEM; i++) mdl_buf[i] = 8'h00;
  endtask

  task automatic model_step();
    bit bad;
    bad     = 1'b0;
    mdl_err = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (bus.flush) begin
      mdl_fill = 0;
      mdl_full = 1'b0;
    end else if (!mdl_full && bus.in_valid) begin
`ifdef MPU_LOADER_FRAME_CHECK_EN
      bad = (bus.in_last == 1'b1) != (mdl_fill == NELEM);
`endif
      if (bad) begin
        mdl_err  = 1'b1;
        mdl_fill = 0;
      end else begin
        mdl_buf[mdl_fill] = bus.in_data;
        mdl_fill++;
        if (mdl_fill == NELEM + 1) mdl_full = 1'b1;
      end
    end else if (mdl_full && bus.out_ready) begin
      mdl_full = 1'b0;
      mdl_fill = 0;
    end
  endtask

  task automatic check_outputs(input string where);
    logic [MW-1:0] exp_mat;
    for (int i = 0; i < NELEM; i++) exp_mat[i*WIDTH +: WIDTH] = mdl_buf[i];
    check_val({where, ":in_ready"},   MW'(bus.in_ready),   MW'(!mdl_full));
    check_val({where, ":out_valid"},  MW'(bus.out_valid),  MW'(mdl_full));
    check_val({where, ":fill_count"}, MW'(bus.fill_count), MW'(mdl_fill));
    check_val({where, ":frame_err"},  MW'(bus.frame_err),  MW'(mdl_err));
    check_val({where, ":factor"},     MW'(bus.factor),     MW'(mdl_buf[NELEM]));
    check_val({where, ":matrix"},     bus.matrix,          exp_mat);
  endtask

  task automatic cycle(input string where);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs(where);
  endtask

  task automatic send_byte(input logic [7:0] data, input logic last, input string where);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    cycle(where);
  endtask

  task automatic idle(input int n, input string where);
    repeat (n) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      bus.in_last  = 1'($urandom);
      cycle(where);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();

    // reset state
    repeat (2) cycle("reset");
    check_val("rst_fill", MW'(bus.fill_count), '0);
    check_val("rst_ready", MW'(bus.in_ready), MW'(1));
    rst_n = 1'b1;
    idle(2, "post_rst");

    // frame 1..25, factor 3, in_valid held, then held for 10 cycles with upstream noise
    for (int k = 0; k <= NELEM; k++)
      send_byte((k < NELEM) ? 8'(k + 1) : 8'd3, k == NELEM, "f1");
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      bus.in_last  = 1'($urandom);
      cycle("f1_hold");
    end
    check_val("f1_e00", MW'(bus.matrix[7:0]), MW'(1));
    check_val("f1_e44", MW'(bus.matrix[MW-1 -: 8]), MW'(25));
    check_val("f1_factor", MW'(bus.factor), MW'(3));
    check_val("f1_fill", MW'(bus.fill_count), MW'(26));

    // one-cycle handoff
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycle("handoff");
    bus.out_ready = 1'b0;
    check_val("ho_valid", MW'(bus.out_valid), '0);
    check_val("ho_fill", MW'(bus.fill_count), '0);
    check_val("ho_ready", MW'(bus.in_ready), MW'(1));

    // frame of 0xFF with factor 0x80
    for (int k = 0; k <= NELEM; k++)
      send_byte((k < NELEM) ? 8'hFF : 8'h80, k == NELEM, "f2");
    check_val("f2_factor", MW'(bus.factor), MW'(8'h80));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycle("f2_ho");
    bus.out_ready = 1'b0;

    // stalled upstream, frame of A0+k
    begin
      int k;
      k = 0;
      while (k <= NELEM) begin
        if ($urandom_range(0, 2) == 0) begin
          idle(1, "stall_gap");
        end else begin
`ifdef MPU_LOADER_FRAME_CHECK_EN
          send_byte(8'(8'hA0 + k), k == NELEM, "stall");
`else
          send_byte(8'(8'hA0 + k), 1'($urandom), "stall");
`endif
          k++;
        end
      end
    end
    for (int k = 0; k < NELEM; k++)
      check_val("stall_elem", MW'(bus.matrix[k*WIDTH +: WIDTH]), MW'(8'hA0 + k));
    check_val("stall_factor", MW'(bus.factor), MW'(8'hA0 + NELEM));
    begin
      int budget;
      budget = 0;
      bus.in_valid = 1'b0;
      while (bus.out_valid && budget < 50) begin
        bus.out_ready = 1'($urandom);
        cycle("rand_ho");
        budget++;
      end
      check_val("rand_ho_timeout", MW'(bus.out_valid), '0);
      bus.out_ready = 1'b0;
      idle(1, "rand_ho_idle");
    end

    // flush with a simultaneous byte after 12 bytes
    for (int k = 0; k < 12; k++) send_byte(8'($urandom), 1'b0, "pre_flush");
    bus.flush = 1'b1;
    send_byte(8'h5A, 1'b0, "flush_load");
    bus.flush = 1'b0;
    check_val("flush_fill", MW'(bus.fill_count), '0);
    check_val("flush_valid", MW'(bus.out_valid), '0);
    for (int k = 0; k <= NELEM; k++) send_byte(8'($urandom), k == NELEM, "f3");
    check_val("f3_valid", MW'(bus.out_valid), MW'(1));
    // flush while FULL with out_ready high
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    cycle("flush_full");
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    check_val("ff_valid", MW'(bus.out_valid), '0);
    check_val("ff_fill", MW'(bus.fill_count), '0);
    idle(2, "ff_idle");

    // asynchronous reset mid-cycle at fill_count 20
    for (int k = 0; k < 20; k++) send_byte(8'($urandom), 1'b0, "pre_arst");
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_fill", MW'(bus.fill_count), '0);
    check_val("arst_valid", MW'(bus.out_valid), '0);
    check_val("arst_ready", MW'(bus.in_ready), MW'(1));
    check_val("arst_matrix", bus.matrix, '0);
    check_val("arst_factor", MW'(bus.factor), '0);
    model_reset();
    cycle("arst_hold");
    rst_n = 1'b1;
    idle(1, "arst_rel");
    for (int k = 0; k <= NELEM; k++) send_byte(8'($urandom), k == NELEM, "f4");
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycle("f4_ho");
    bus.out_ready = 1'b0;

`ifdef MPU_LOADER_FRAME_CHECK_EN
    // early end on byte 10
    for (int k = 0; k < 9; k++) send_byte(8'($urandom), 1'b0, "early");
    send_byte(8'hEE, 1'b1, "early_last");
    check_val("early_err", MW'(bus.frame_err), MW'(1));
    check_val("early_fill", MW'(bus.fill_count), '0);
    idle(1, "early_idle");
    check_val("early_pulse", MW'(bus.frame_err), '0);
    // missing end on byte 26
    for (int k = 0; k <= NELEM; k++) send_byte(8'($urandom), 1'b0, "noend");
    check_val("noend_err", MW'(bus.frame_err), MW'(1));
    check_val("noend_valid", MW'(bus.out_valid), '0);
    idle(2, "noend_idle");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mpu_matrix_loader.md
Name: mpu_matrix_loader

Overview:
Upstream feeder for the MPU integer scalar-multiply stage. It accepts a byte stream over a valid/ready handshake and assembles a 5x5 matrix of 8-bit elements plus one 8-bit factor into a register buffer. It then presents the complete operand set to the multiplier and holds it stable until the multiplier accepts it. One frame is 26 bytes: 25 matrix elements in row-major order, then the factor.

Parameters:
DIM, 5, matrix dimension (rows = cols)
WIDTH, 8, element and factor width in bits

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort: discard partial or held frame
in_data  input  WIDTH  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte
in_last  input  1  marks final byte of frame (used only with MPU_LOADER_FRAME_CHECK_EN)
matrix  output  DIM*DIM*WIDTH  assembled matrix; element (i,j) at bits [(i*DIM+j)*WIDTH +: WIDTH]
factor  output  WIDTH  assembled factor
out_valid  output  1  matrix/factor complete and stable
out_ready  input  1  multiplier accepts operands
fill_count  output  5  bytes accepted in current frame, 0..26
frame_err  output  1  one-cycle pulse on framing error (0 when feature off)

Behaviour:
- Reset (rst_n low, asynchronous): state LOAD, fill_count 0, out_valid 0, matrix all 0, factor 0, frame_err 0. The same applies when reset is asserted mid-frame or while FULL; any partial data is lost.
- States:
  - LOAD: in_ready=1, out_valid=0.
  - FULL: in_ready=0, out_valid=1.
- Byte accept: in_valid && in_ready on a rising edge.
  - Index k = fill_count before the accept.
  - k<25: byte written to element k (i=k/5, j=k%5); fill_count increments.
  - k=25: byte written to factor; fill_count becomes 26; state becomes FULL. out_valid is seen high the cycle after the last accept.
- FULL:
  - matrix, factor and fill_count are held constant.
  - On out_valid && out_ready: state becomes LOAD and fill_count becomes 0. in_ready rises the next cycle (one-cycle bubble; no same-cycle reload).
  - matrix/factor registers retain their old values after handoff until overwritten.
- out_valid, once high, stays high until accepted or until flush/reset. It is never withdrawn by upstream activity.
- flush: takes priority over any accept or handoff in the same cycle. Next state is LOAD, fill_count 0, out_valid 0. Buffer contents are not cleared.
- in_valid while in LOAD with no byte pending: no effect. in_data is ignored whenever the byte is not accepted.
- Pure register storage; no arithmetic on data. fill_count never exceeds 26.

Optional Feature:
Macro: MPU_LOADER_FRAME_CHECK_EN.
- Defined:
  - in_last is checked on every accepted byte.
  - in_last=1 with k<25 (early end): frame_err pulses one cycle, the byte is discarded, fill_count becomes 0, state stays LOAD.
  - k=25 with in_last=0 (missing end): frame_err pulses, the byte is discarded, fill_count becomes 0, no transition to FULL.
  - Correct frame: identical to the undefined case.
- Undefined: in_last is ignored, frame_err is tied to 0, and framing is by count only.

Test Plan:
- Reset, then stream bytes 1..25 followed by factor 3 with in_valid held high and out_ready=0 -> in_ready=0, out_valid=1 one cycle after the 26th accept; element(0,0)=1, element(4,4)=25, factor=3, fill_count=26; all held for 10 cycles.
- From FULL, pulse out_ready for one cycle -> out_valid=0 and fill_count=0 next cycle, in_ready=1; a second frame of 0xFF bytes with factor 0x80 loads correctly.
- Stall upstream: random in_valid gaps during a frame of 8'hA0+k -> element k = 8'hA0+k for all k; fill_count tracks accepts exactly.
- After 12 bytes, assert flush simultaneously with in_valid -> the byte is not accepted, fill_count=0, out_valid=0; a following full frame loads cleanly. Repeat flush while FULL with out_ready=1 -> out_valid=0, no handoff counted.
- Assert rst_n low asynchronously (mid-cycle) at fill_count=20 -> outputs go to reset values immediately without waiting for a clock edge.
- With MPU_LOADER_FRAME_CHECK_EN defined: in_last on byte 10 -> frame_err pulses once, fill_count=0. Frame of 26 bytes with in_last=0 on the last byte -> frame_err pulses, out_valid stays 0.
